// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch stage
//
// Purpose: FSM state encoding and default widths shared by fetch_unit and
//          its output latch (and later by the decode latch).
// Contents:
//   fetch_state_e - IDLE=0, RUN=1, HALTED=2
//   AW_DEFAULT    - default PC/address width
//   IW_DEFAULT    - default instruction width
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  localparam int AW_DEFAULT = 16;
  localparam int IW_DEFAULT = 16;

endpackage

// File: rtl/fetch_out_latch.sv
// rtl/fetch_out_latch.sv - valid/ready output register with load/flush/hold
//
// Purpose: holds one instruction plus its PC and next PC for the downstream
//          stage. Flush has priority over load; with neither, an accepted
//          entry (valid && ready_i) empties the latch and an unaccepted one
//          is held unchanged.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (clears everything)
//   load_i       - capture instr_i/pc_i/next_pc_i and set valid
//   flush_i      - drop the current entry (data fields keep their values)
//   ready_i      - downstream accepts the entry this cycle
//   instr_i, pc_i, next_pc_i - data to capture on load
//   valid_o, instr_o, pc_o, next_pc_o - registered latch contents
module fetch_out_latch import fetch_pkg::*; #(
  parameter int AW = AW_DEFAULT,
  parameter int IW = IW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          flush_i,
  input  logic          ready_i,
  input  logic [IW-1:0] instr_i,
  input  logic [AW-1:0] pc_i,
  input  logic [AW-1:0] next_pc_i,
  output logic          valid_o,
  output logic [IW-1:0] instr_o,
  output logic [AW-1:0] pc_o,
  output logic [AW-1:0] next_pc_o
);

  logic          valid_q,   valid_d;
  logic [IW-1:0] instr_q,   instr_d;
  logic [AW-1:0] pc_q,      pc_d;
  logic [AW-1:0] next_pc_q, next_pc_d;

  always_comb begin
    valid_d   = valid_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    next_pc_d = next_pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d   = 1'b1;
      instr_d   = instr_i;
      pc_d      = pc_i;
      next_pc_d = next_pc_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      instr_q   <= '0;
      pc_q      <= '0;
      next_pc_q <= '0;
    end else begin
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      next_pc_q <= next_pc_d;
    end
  end

  assign valid_o   = valid_q;
  assign instr_o   = instr_q;
  assign pc_o      = pc_q;
  assign next_pc_o = next_pc_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with start/halt, redirect and backpressure
//
// Purpose: owns the PC and run/halt FSM, drives a combinational instruction
//          memory and registers each fetched instruction into an output latch
//          with a valid/ready handshake toward decode.
// Optional feature macro: FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   start, halt_req          - run control pulses (halt wins when both set)
//   redirect_valid/_pc       - load new PC and flush the output latch
//   imem_addr / imem_rdata   - instruction memory address (= pc) and same-cycle data
//   out_valid/out_ready      - handshake to decode
//   out_instr/out_pc/out_next_pc - latched instruction, its PC, PC + PC_INC
//   fetch_count, stall_count - performance counters (FETCH_PERF_CNT_EN only)
module fetch_unit import fetch_pkg::*; #(
  parameter int              AW       = AW_DEFAULT,
  parameter int              IW       = IW_DEFAULT,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter int              PC_INC   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          halt_req,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_instr,
  output logic [AW-1:0] out_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]   fetch_count,
  output logic [31:0]   stall_count,
`endif
  output logic [AW-1:0] out_next_pc
);

  localparam logic [AW-1:0] PC_STEP = AW'(PC_INC);

  fetch_state_e  state_q;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] pc_plus;
  logic          fetch;

  // Addition truncates to AW bits, giving the modulo-2^AW wrap for free.
  assign pc_plus = pc_q + PC_STEP;

  // Fetch only in RUN, when nothing is cancelling this cycle, and when the
  // latch is empty or being emptied by decode.
  assign fetch = (state_q == ST_RUN) && !halt_req && !redirect_valid &&
                 (!out_valid || out_ready);

  // Run-control FSM. A simultaneous start+halt lands in HALTED from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else if (start && halt_req) begin
      state_q <= ST_HALTED;
    end else begin
      case (state_q)
        ST_IDLE:   if (start)    state_q <= ST_RUN;
        ST_RUN:    if (halt_req) state_q <= ST_HALTED;
        ST_HALTED: if (start)    state_q <= ST_RUN;
        default:                 state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (fetch) begin
      pc_d = pc_plus;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign imem_addr = pc_q;

  fetch_out_latch #(
    .AW(AW),
    .IW(IW)
  ) u_out_latch (
    .clk       (clk),
    .rst       (rst),
    .load_i    (fetch),
    .flush_i   (redirect_valid),
    .ready_i   (out_ready),
    .instr_i   (imem_rdata),
    .pc_i      (pc_q),
    .next_pc_i (pc_plus),
    .valid_o   (out_valid),
    .instr_o   (out_instr),
    .pc_o      (out_pc),
    .next_pc_o (out_next_pc)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q;
  logic [31:0] stall_count_q;
  logic        stall;

  // A redirect cycle flushes rather than stalls, so it is excluded here.
  assign stall = (state_q == ST_RUN) && out_valid && !out_ready && !redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (fetch && (fetch_count_q != 32'hFFFF_FFFF)) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
      if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        halt_req;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [15:0] out_next_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int tests_run;
  int tests_failed;

  fetch_unit #(
    .AW(16),
    .IW(16),
    .RESET_PC(16'h0000),
    .PC_INC(1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count    (fetch_count),
    .stall_count    (stall_count),
`endif
    .out_next_pc    (out_next_pc)
  );

  // Instruction memory model: each word is 0x1000 + its address (16-bit wrap).
  assign imem_rdata = 16'h1000 + imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle past the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_entry(input string tag, input logic [15:0] pc);
    logic [15:0] exp_instr;
    logic [15:0] exp_next;
    exp_instr = 16'h1000 + pc;
    exp_next  = pc + 16'd1;
    check({tag, ".valid"},   {31'd0, out_valid}, 32'd1);
    check({tag, ".pc"},      {16'd0, out_pc},      {16'd0, pc});
    check({tag, ".instr"},   {16'd0, out_instr},   {16'd0, exp_instr});
    check({tag, ".next_pc"}, {16'd0, out_next_pc}, {16'd0, exp_next});
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst            = 1'b1;
    start          = 1'b0;
    halt_req       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    out_ready      = 1'b0;

    // Reset then idle.
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("idle.valid",   {31'd0, out_valid},   32'd0);
      check("idle.addr",    {16'd0, imem_addr},   32'd0);
      check("idle.pc",      {16'd0, out_pc},      32'd0);
      check("idle.instr",   {16'd0, out_instr},   32'd0);
      check("idle.next_pc", {16'd0, out_next_pc}, 32'd0);
      step();
    end

    // Streaming: start enters RUN, first fetch lands one cycle later.
    start     = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    check("start.valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_entry("stream", 16'(i));
    end
    check("stream.addr", {16'd0, imem_addr}, 32'd5);

    // Backpressure: entry pc=4 held, imem_addr held at 5.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_entry("stall", 16'd4);
      check("stall.addr", {16'd0, imem_addr}, 32'd5);
    end
    out_ready = 1'b1;
    step();
    check_entry("unstall", 16'd5);

    // Redirect flushes a valid, accepted entry.
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    step();
    redirect_valid = 1'b0;
    check("redir.valid", {31'd0, out_valid}, 32'd0);
    check("redir.addr",  {16'd0, imem_addr}, 32'h40);
    step();
    check_entry("redir.first", 16'h0040);

    // Set up pc=7 with a pending entry at 6, then halt with decode stalled.
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0006;
    step();
    redirect_valid = 1'b0;
    step();
    check_entry("pre_halt", 16'd6);
    halt_req  = 1'b1;
    out_ready = 1'b0;
    step();
    halt_req = 1'b0;
    check_entry("halt.hold", 16'd6);
    check("halt.addr", {16'd0, imem_addr}, 32'd7);
    step();
    check_entry("halted.hold", 16'd6);
    out_ready = 1'b1;
    step();
    check("drain.valid", {31'd0, out_valid}, 32'd0);
    check("drain.addr",  {16'd0, imem_addr}, 32'd7);

    // start + halt together keeps HALTED.
    start    = 1'b1;
    halt_req = 1'b1;
    step();
    start    = 1'b0;
    halt_req = 1'b0;
    step();
    check("both.valid", {31'd0, out_valid}, 32'd0);
    check("both.addr",  {16'd0, imem_addr}, 32'd7);

    // start alone resumes at pc=7.
    start = 1'b1;
    step();
    start = 1'b0;
    check("resume.valid0", {31'd0, out_valid}, 32'd0);
    step();
    check_entry("resume", 16'd7);

    // PC wrap at 0xFFFF.
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFF;
    step();
    redirect_valid = 1'b0;
    check("wrap.flush", {31'd0, out_valid}, 32'd0);
    step();
    check_entry("wrap.top", 16'hFFFF);
    step();
    check_entry("wrap.zero", 16'h0000);

    // Reset during a stall discards latch and PC.
    out_ready = 1'b0;
    step();
    check_entry("pre_rst.stall", 16'h0000);
    check("pre_rst.addr", {16'd0, imem_addr}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst.valid", {31'd0, out_valid},   32'd0);
    check("rst.addr",  {16'd0, imem_addr},   32'd0);
    check("rst.pc",    {16'd0, out_pc},      32'd0);
    check("rst.instr", {16'd0, out_instr},   32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("rst.fetch_count", fetch_count, 32'd0);
    check("rst.stall_count", stall_count, 32'd0);
`endif
    out_ready = 1'b1;
    step();
    check("rst.idle_valid", {31'd0, out_valid}, 32'd0);
    check("rst.idle_addr",  {16'd0, imem_addr}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
